sopc_system_linux_cpu_oci_dct_packer: RTL and testbench



---
 rtl/sopc_system_linux_cpu_oci_dct_packer_if.sv | 29 ++
 rtl/sopc_system_linux_cpu_oci_dct_packer.sv | 107 ++++++++++
 tb/tb_sopc_system_linux_cpu_oci_dct_packer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sopc_system_linux_cpu_oci_dct_packer_if.sv
// Symbol-in / frame-out bus of the OCI DCT frame packer.
// The slave modport is the packer; master is the symbol source and frame consumer.
interface sopc_system_linux_cpu_oci_dct_packer_if;
  localparam int unsigned SYM_W  = 2;
  localparam int unsigned SLOTS  = 15;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned BUF_W  = SLOTS * SYM_W;

  logic              sym_valid;
  logic [SYM_W-1:0]  sym_data;
  logic              sym_ready;
  logic              flush;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              frame_valid;
  logic              frame_ready;
  logic [FCNT_W-1:0] frames_sent;

  modport slave (
    input  sym_valid, sym_data, flush, frame_ready,
    output sym_ready, dct_buffer, dct_count, frame_valid, frames_sent
  );

  modport master (
    output sym_valid, sym_data, flush, frame_ready,
    input  sym_ready, dct_buffer, dct_count, frame_valid, frames_sent
  );
endinterface

// File: rtl/sopc_system_linux_cpu_oci_dct_packer.sv
// OCI DCT transmit packer: gathers 2-bit trace symbols into 15-slot frames
// behind an accumulator stage and a valid/ready output register.
module sopc_system_linux_cpu_oci_dct_packer (
  input  logic                                    clk,
  input  logic                                    reset,
  sopc_system_linux_cpu_oci_dct_packer_if.slave   bus
);
  localparam int unsigned SYM_W  = 2;
  localparam int unsigned SLOTS  = 15;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned BUF_W  = SLOTS * SYM_W;

  logic [BUF_W-1:0]  acc_q,         acc_d;
  logic [CNT_W-1:0]  acc_cnt_q,     acc_cnt_d;
  logic              flush_pending_q, flush_pending_d;
  logic [BUF_W-1:0]  dct_buffer_q,  dct_buffer_d;
  logic [CNT_W-1:0]  dct_count_q,   dct_count_d;
  logic              frame_valid_q, frame_valid_d;
  logic [FCNT_W-1:0] frames_sent_q, frames_sent_d;

  logic out_free_c;
  logic acc_full_c;
  logic move_c;
  logic sym_ready_c;
  logic accept_c;
  logic handshake_c;

  // Transfer decision: the accumulator hands over when full, or when a flush is owed.
  always_comb begin
    out_free_c  = !frame_valid_q || bus.frame_ready;
    acc_full_c  = (acc_cnt_q == CNT_W'(SLOTS));
    move_c      = out_free_c &&
                  (acc_full_c || (flush_pending_q && (acc_cnt_q != CNT_W'(0))));
    sym_ready_c = !reset && (!acc_full_c || move_c);
    accept_c    = bus.sym_valid && sym_ready_c;
    handshake_c = frame_valid_q && bus.frame_ready;
  end

  always_comb begin
    acc_d           = acc_q;
    acc_cnt_d       = acc_cnt_q;
    flush_pending_d = flush_pending_q;
    dct_buffer_d    = dct_buffer_q;
    dct_count_d     = dct_count_q;
    frame_valid_d   = frame_valid_q;
    frames_sent_d   = frames_sent_q;

    // Accumulator: a symbol accepted in a move cycle starts the next frame.
    if (accept_c && move_c) begin
      acc_d     = BUF_W'(bus.sym_data);
      acc_cnt_d = CNT_W'(1);
    end else if (accept_c) begin
      acc_d[32'(acc_cnt_q) * SYM_W +: SYM_W] = bus.sym_data;
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end else if (move_c) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end

    // A flush is satisfied by any move, or dropped when there is nothing to send.
    if (move_c) begin
      flush_pending_d = 1'b0;
    end else if (bus.flush || flush_pending_q) begin
      flush_pending_d = (acc_cnt_q != CNT_W'(0)) || accept_c;
    end

    if (move_c) begin
      dct_buffer_d  = acc_q;
      dct_count_d   = acc_cnt_q;
      frame_valid_d = 1'b1;
    end else if (handshake_c) begin
      frame_valid_d = 1'b0;
    end

    if (handshake_c) begin
      frames_sent_d = frames_sent_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q           <= '0;
      acc_cnt_q       <= '0;
      flush_pending_q <= 1'b0;
      dct_buffer_q    <= '0;
      dct_count_q     <= '0;
      frame_valid_q   <= 1'b0;
      frames_sent_q   <= '0;
    end else begin
      acc_q           <= acc_d;
      acc_cnt_q       <= acc_cnt_d;
      flush_pending_q <= flush_pending_d;
      dct_buffer_q    <= dct_buffer_d;
      dct_count_q     <= dct_count_d;
      frame_valid_q   <= frame_valid_d;
      frames_sent_q   <= frames_sent_d;
    end
  end

  assign bus.sym_ready   = sym_ready_c;
  assign bus.dct_buffer  = dct_buffer_q;
  assign bus.dct_count   = dct_count_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_sopc_system_linux_cpu_oci_dct_packer.sv
// Directed bench for the OCI DCT packer; expected frames are hand-packed
// with symbol i at bits [2i+1:2i].
module tb_sopc_system_linux_cpu_oci_dct_packer;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  sopc_system_linux_cpu_oci_dct_packer_if bus ();

  sopc_system_linux_cpu_oci_dct_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.sym_valid   = 1'b0;
    bus.sym_data    = 2'd0;
    bus.flush       = 1'b0;
    bus.frame_ready = 1'b0;
    #1;
    n_vec++;
    if (bus.sym_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_sym_ready: got %b want 0", bus.sym_ready);
    end
    cyc(); cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b0 || bus.dct_count !== 4'd0 ||
        bus.dct_buffer !== 30'd0 || bus.frames_sent !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got fv=%b cnt=%0d buf=%h sent=%0d want 0/0/0/0",
               bus.frame_valid, bus.dct_count, bus.dct_buffer, bus.frames_sent);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_full_frame();
    bit ok = 1'b1;
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'(i % 4);
      #1;
      if (bus.sym_ready !== 1'b1) ok = 1'b0;
      cyc();
    end
    bus.sym_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL full_sym_ready: got 0 during fill want 1");
    end
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd15 || bus.dct_buffer !== 30'h24E4E4E4) begin
      n_err++;
      $display("FAIL full_frame: got fv=%b cnt=%0d buf=%h want 1/15/24e4e4e4",
               bus.frame_valid, bus.dct_count, bus.dct_buffer);
    end
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b0 || bus.frames_sent !== 16'd1) begin
      n_err++;
      $display("FAIL full_handshake: got fv=%b sent=%0d want 0/1", bus.frame_valid, bus.frames_sent);
    end
  endtask

  task automatic test_flush_partial();
    logic [1:0] syms [3] = '{2'd3, 2'd2, 2'd1};
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = syms[i];
      cyc();
    end
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b1;
    cyc();
    bus.flush = 1'b0;
    n_vec++;
    if (bus.frame_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_latency: got fv=%b want 0", bus.frame_valid);
    end
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd3 || bus.dct_buffer !== 30'h0000001B) begin
      n_err++;
      $display("FAIL flush_partial: got fv=%b cnt=%0d buf=%h want 1/3/0000001b",
               bus.frame_valid, bus.dct_count, bus.dct_buffer);
    end
    cyc();
    n_vec++;
    if (bus.frames_sent !== 16'd2) begin
      n_err++; $display("FAIL flush_sent: got %0d want 2", bus.frames_sent);
    end
  endtask

  task automatic test_flush_empty();
    bit quiet = 1'b1;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.frame_valid !== 1'b0) quiet = 1'b0;
      cyc();
    end
    // One symbol afterwards must not be pushed out by the stale flush.
    bus.sym_valid = 1'b1;
    bus.sym_data  = 2'd3;
    cyc();
    bus.sym_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.frame_valid !== 1'b0) quiet = 1'b0;
      cyc();
    end
    n_vec++;
    if (!quiet || bus.frames_sent !== 16'd2) begin
      n_err++;
      $display("FAIL flush_empty: got quiet=%b sent=%0d want 1/2", quiet, bus.frames_sent);
    end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd1 || bus.dct_buffer !== 30'h00000003) begin
      n_err++;
      $display("FAIL flush_single: got fv=%b cnt=%0d buf=%h want 1/1/00000003",
               bus.frame_valid, bus.dct_count, bus.dct_buffer);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    int  nfr = 0;
    bit  stable = 1'b1;
    bit  last_rdy = 1'b1;
    bit  quiet = 1'b1;
    bus.frame_ready = 1'b0;
    for (int c = 0; c < 35; c++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd2;
      #1;
      last_rdy = bus.sym_ready;
      if (bus.sym_ready) sent++;
      if (bus.frame_valid &&
          (bus.dct_buffer !== 30'h2AAAAAAA || bus.dct_count !== 4'd15 || bus.frames_sent !== 16'd3))
        stable = 1'b0;
      cyc();
    end
    n_vec++;
    if (!stable) begin
      n_err++; $display("FAIL bp_hold: got unstable held frame want 2aaaaaaa/15 sent 3");
    end
    n_vec++;
    if (sent != 30 || last_rdy !== 1'b0) begin
      n_err++; $display("FAIL bp_stall: got accepts=%0d ready=%b want 30/0", sent, last_rdy);
    end
    bus.frame_ready = 1'b1;
    for (int c = 0; c < 20 && sent < 40; c++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd2;
      #1;
      if (bus.frame_valid) begin
        nfr++;
        if (bus.dct_buffer !== 30'h2AAAAAAA || bus.dct_count !== 4'd15) stable = 1'b0;
      end
      if (bus.sym_ready) sent++;
      cyc();
    end
    bus.sym_valid = 1'b0;
    n_vec++;
    if (sent != 40 || nfr != 2 || !stable) begin
      n_err++;
      $display("FAIL bp_release: got accepts=%0d frames=%0d ok=%b want 40/2/1", sent, nfr, stable);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.frame_valid !== 1'b0) quiet = 1'b0;
      cyc();
    end
    n_vec++;
    if (!quiet) begin
      n_err++; $display("FAIL bp_no_auto_emit: got fv=1 want 0");
    end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd10 ||
        bus.dct_buffer !== 30'h000AAAAA || bus.frames_sent !== 16'd5) begin
      n_err++;
      $display("FAIL bp_tail: got fv=%b cnt=%0d buf=%h sent=%0d want 1/10/000aaaaa/5",
               bus.frame_valid, bus.dct_count, bus.dct_buffer, bus.frames_sent);
    end
    cyc();
    n_vec++;
    if (bus.frames_sent !== 16'd6) begin
      n_err++; $display("FAIL bp_sent: got %0d want 6", bus.frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    int nfr = 0;
    bit rdy_ok = 1'b1;
    test_reset();
    bus.frame_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'(c % 4);
      #1;
      if (bus.sym_ready !== 1'b1) rdy_ok = 1'b0;
      if (bus.frame_valid) nfr++;
      cyc();
    end
    bus.sym_valid = 1'b0;
    n_vec++;
    if (!rdy_ok || nfr != 2) begin
      n_err++; $display("FAIL b2b_stream: got ready_ok=%b frames=%0d want 1/2", rdy_ok, nfr);
    end
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd15) begin
      n_err++; $display("FAIL b2b_third: got fv=%b cnt=%0d want 1/15", bus.frame_valid, bus.dct_count);
    end
    cyc();
    n_vec++;
    if (bus.frames_sent !== 16'd3) begin
      n_err++; $display("FAIL b2b_sent: got %0d want 3", bus.frames_sent);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit quiet = 1'b1;
    bus.frame_ready = 1'b0;
    for (int c = 0; c < 22; c++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd1;
      cyc();
    end
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd15) begin
      n_err++; $display("FAIL mid_setup: got fv=%b cnt=%0d want 1/15", bus.frame_valid, bus.dct_count);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.sym_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_ready: got %b want 0", bus.sym_ready);
    end
    cyc();
    n_vec++;
    if (bus.frame_valid !== 1'b0 || bus.dct_count !== 4'd0 ||
        bus.dct_buffer !== 30'd0 || bus.frames_sent !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset: got fv=%b cnt=%0d buf=%h sent=%0d want 0/0/0/0",
               bus.frame_valid, bus.dct_count, bus.dct_buffer, bus.frames_sent);
    end
    reset         = 1'b0;
    bus.sym_valid = 1'b0;
    bus.frame_ready = 1'b1;
    bus.flush     = 1'b1;
    cyc();
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.frame_valid !== 1'b0) quiet = 1'b0;
      cyc();
    end
    n_vec++;
    if (!quiet || bus.frames_sent !== 16'd0) begin
      n_err++; $display("FAIL mid_flush: got quiet=%b sent=%0d want 1/0", quiet, bus.frames_sent);
    end
  endtask

  task automatic test_flush_full();
    bit quiet = 1'b1;
    bus.frame_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd3;
      cyc();
    end
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b1;
    cyc();
    bus.flush = 1'b0;
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.dct_count !== 4'd15 || bus.dct_buffer !== 30'h3FFFFFFF) begin
      n_err++;
      $display("FAIL flush_full: got fv=%b cnt=%0d buf=%h want 1/15/3fffffff",
               bus.frame_valid, bus.dct_count, bus.dct_buffer);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (bus.frame_valid !== 1'b0) quiet = 1'b0;
      cyc();
    end
    n_vec++;
    if (!quiet || bus.frames_sent !== 16'd1) begin
      n_err++; $display("FAIL flush_full_extra: got quiet=%b sent=%0d want 1/1", quiet, bus.frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_flush_partial();
    test_flush_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_flush_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
